// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   - ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   - arb_state_e / ST_*      : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   - OWN_CPU / OWN_DBG       : one-bit owner encoding of a transaction
//   - rr_winner()             : contended winner when alternation is enabled
// Optional feature macro used by this slice: DM_ARB_RR_EN (round-robin
// contention instead of fixed CPU priority).
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

  // Plain constants so the state register stays a bare logic vector.
  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_ACCESS = ARB_ACCESS;
  localparam logic [1:0] ST_RESP   = ARB_RESP;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // The requester that did not win last time takes the contended grant.
  function automatic logic rr_winner(input logic last_own);
    logic w;
    if (last_own == OWN_CPU) begin
      w = OWN_DBG;
    end else begin
      w = OWN_CPU;
    end
    return w;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// -----------------------------------------------------------------------------
// dm_arb_pick
// Combinational winner selection between the CPU and debug requesters.
// Ports:
//   cpu_req  in  CPU request
//   dbg_req  in  debug request
//   last_own in  owner of the previous grant (only with DM_ARB_RR_EN)
//   own      out selected owner (OWN_CPU / OWN_DBG)
//   vld      out at least one request is present
// Macro: DM_ARB_RR_EN -- contended grants alternate; otherwise CPU always wins.
// -----------------------------------------------------------------------------
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
`ifdef DM_ARB_RR_EN
  input  logic last_own,
`endif
  output logic own,
  output logic vld
);

  // Winner decode: contention is the only case where a policy is needed.
  always_comb begin
    vld = cpu_req | dbg_req;
    own = OWN_CPU;
    if (cpu_req && dbg_req) begin
`ifdef DM_ARB_RR_EN
      own = rr_winner(last_own);
`else
      own = OWN_CPU;
`endif
    end else if (dbg_req) begin
      own = OWN_DBG;
    end else begin
      own = OWN_CPU;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares one single-port data memory between the pipeline MEM stage (CPU) and
// a debug/initialisation port. Each access takes IDLE -> ACCESS -> RESP, so a
// request first seen in IDLE cycle N is acknowledged in cycle N+2.
// Ports:
//   clk                          clock, all state on rising edge
//   clr                          synchronous active-low reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata   CPU request fields (held until ack)
//   cpu_ack/cpu_rdata/cpu_stall          CPU completion, read data, hold
//   dbg_req/dbg_wr/dbg_addr/dbg_wdata   debug request fields
//   dbg_ack/dbg_rdata                    debug completion, read data
//   dm_ra/dm_d/dm_load/dm_str/dm_sel     memory address, data, strobes
//   dm_a_out                             memory read data
// Macro: DM_ARB_RR_EN -- alternate contended grants using a last-owner
// register; without it the CPU always wins and no last-owner state exists.
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] dm_ra,
  output logic [DATA_W-1:0] dm_d,
  output logic              dm_load,
  output logic              dm_str,
  output logic              dm_sel,
  input  logic [DATA_W-1:0] dm_a_out
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              own_r;
  logic              wr_r;
  logic [ADDR_W-1:0] dm_ra_r;
  logic [DATA_W-1:0] dm_d_r;
  logic              dm_sel_r;
  logic              dm_load_r;
  logic              dm_str_r;
  logic              cpu_ack_r;
  logic              dbg_ack_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] dbg_rdata_r;

  logic              pick_own_s;
  logic              pick_vld_s;
  logic              grant_s;
  logic              sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

`ifdef DM_ARB_RR_EN
  logic              last_own_r;
`endif

  dm_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
`ifdef DM_ARB_RR_EN
    .last_own (last_own_r),
`endif
    .own      (pick_own_s),
    .vld      (pick_vld_s)
  );

  // Requests are only sampled in IDLE; RESP never starts a new access.
  assign grant_s = (state_r == ST_IDLE) && pick_vld_s;

  // Route the winning requester's fields toward the latch.
  always_comb begin
    sel_wr_s    = cpu_wr;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
    if (pick_own_s == OWN_DBG) begin
      sel_wr_s    = dbg_wr;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_wr_s    = cpu_wr;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Owner and direction latch; held through RESP so capture and ack can use it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      own_r <= OWN_CPU;
      wr_r  <= 1'b0;
    end else if (grant_s) begin
      own_r <= pick_own_s;
      wr_r  <= sel_wr_s;
    end else if (state_r == ST_RESP) begin
      own_r <= OWN_CPU;
      wr_r  <= 1'b0;
    end else begin
      own_r <= own_r;
      wr_r  <= wr_r;
    end
  end

  // Memory-facing registers: loaded on grant so they are valid exactly in
  // ACCESS, and zero in every other state. The latched address and write
  // data live here directly.
  always_ff @(posedge clk) begin
    if (!clr) begin
      dm_ra_r   <= {ADDR_W{1'b0}};
      dm_d_r    <= {DATA_W{1'b0}};
      dm_sel_r  <= 1'b0;
      dm_load_r <= 1'b0;
      dm_str_r  <= 1'b0;
    end else if (grant_s) begin
      dm_ra_r   <= sel_addr_s;
      dm_d_r    <= sel_wdata_s;
      dm_sel_r  <= 1'b1;
      dm_load_r <= ~sel_wr_s;
      dm_str_r  <= sel_wr_s;
    end else begin
      dm_ra_r   <= {ADDR_W{1'b0}};
      dm_d_r    <= {DATA_W{1'b0}};
      dm_sel_r  <= 1'b0;
      dm_load_r <= 1'b0;
      dm_str_r  <= 1'b0;
    end
  end

  // Completion pulses: set on the ACCESS->RESP edge, so each lasts one cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cpu_ack_r <= 1'b0;
      dbg_ack_r <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      cpu_ack_r <= (own_r == OWN_CPU);
      dbg_ack_r <= (own_r == OWN_DBG);
    end else begin
      cpu_ack_r <= 1'b0;
      dbg_ack_r <= 1'b0;
    end
  end

  // Read-data capture: only reads update, and only the owner's register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cpu_rdata_r <= {DATA_W{1'b0}};
      dbg_rdata_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !wr_r) begin
      if (own_r == OWN_DBG) begin
        dbg_rdata_r <= dm_a_out;
      end else begin
        cpu_rdata_r <= dm_a_out;
      end
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
      dbg_rdata_r <= dbg_rdata_r;
    end
  end

`ifdef DM_ARB_RR_EN
  // Last-owner tracking: every grant, contended or not, updates it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      last_own_r <= OWN_DBG;
    end else if (grant_s) begin
      last_own_r <= pick_own_s;
    end else begin
      last_own_r <= last_own_r;
    end
  end
`endif

  // Strobes are qualified with clr so an access being reset cannot store:
  // the memory samples dm_str on the same edge that applies the reset.
  assign dm_sel    = dm_sel_r  & clr;
  assign dm_load   = dm_load_r & clr;
  assign dm_str    = dm_str_r  & clr;
  assign dm_ra     = dm_ra_r;
  assign dm_d      = dm_d_r;
  assign cpu_ack   = cpu_ack_r;
  assign dbg_ack   = dbg_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign dbg_rdata = dbg_rdata_r;
  assign cpu_stall = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with an attached 64-word memory, a
// transaction-level reference model compared every cycle, and literal checks.
// Honours DM_ARB_RR_EN for the contention expectations.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  logic        clk;
  logic        clr;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [5:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, cpu_stall, dbg_ack;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [5:0]  dm_ra;
  logic [31:0] dm_d, dm_a_out;
  logic        dm_load, dm_str, dm_sel;

  int checks;
  int errors;

  dm_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_ra(dm_ra), .dm_d(dm_d), .dm_load(dm_load), .dm_str(dm_str), .dm_sel(dm_sel),
    .dm_a_out(dm_a_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the data-memory port.
  logic [31:0] mem [64];
  assign dm_a_out = mem[dm_ra];
  always @(posedge clk) if (dm_str) mem[dm_ra] <= dm_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction schedule) ----------------
  logic [31:0] ref_mem [64];
  int          cyc, m_g;
  bit          m_ok, m_act, m_own, m_wr, m_last, acc, resp;
  logic [5:0]  m_addr;
  logic [31:0] m_data, m_cpu_rd, m_dbg_rd;

  initial begin
    cyc = 0; m_g = 0; m_ok = 0; m_act = 0; m_own = 0; m_wr = 0; m_last = 1;
    m_addr = 6'd0; m_data = 32'd0; m_cpu_rd = 32'd0; m_dbg_rd = 32'd0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hA5000000 | 32'(i);
      mem[i] <= 32'hA5000000 | 32'(i);
    end
    ref_mem[5] = 32'h1234ABCD;
    mem[5] <= 32'h1234ABCD;
  end

  // A grant in cycle g means memory access in g+1, ack in g+2, free from g+3.
  always @(negedge clk) begin
    if (m_ok) begin
      acc  = m_act && (cyc == m_g + 1);
      resp = m_act && (cyc == m_g + 2);
      chk("m_dm_sel",  32'(dm_sel),  32'(acc && clr));
      chk("m_dm_load", 32'(dm_load), 32'(acc && !m_wr && clr));
      chk("m_dm_str",  32'(dm_str),  32'(acc && m_wr && clr));
      chk("m_dm_ra",   32'(dm_ra),   acc ? 32'(m_addr) : 32'd0);
      chk("m_dm_d",    dm_d,         acc ? m_data : 32'd0);
      chk("m_cpu_ack", 32'(cpu_ack), 32'(resp && !m_own));
      chk("m_dbg_ack", 32'(dbg_ack), 32'(resp && m_own));
      chk("m_cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("m_dbg_rdata", dbg_rdata, m_dbg_rd);
      chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(resp && !m_own)));
    end
    if (!clr) begin
      m_ok = 1; m_act = 0; m_cpu_rd = 32'd0; m_dbg_rd = 32'd0; m_last = 1;
    end else if (m_ok) begin
      if (m_act && (cyc == m_g + 1)) begin
        if (m_wr) ref_mem[m_addr] = m_data;
        else if (m_own) m_dbg_rd = ref_mem[m_addr];
        else m_cpu_rd = ref_mem[m_addr];
      end
      if ((!m_act || cyc >= m_g + 3) && (cpu_req || dbg_req)) begin
        if (cpu_req && dbg_req) begin
`ifdef DM_ARB_RR_EN
          m_own = !m_last;
`else
          m_own = 0;
`endif
        end else begin
          m_own = dbg_req;
        end
        m_last = m_own;
        m_wr   = m_own ? dbg_wr : cpu_wr;
        m_addr = m_own ? dbg_addr : cpu_addr;
        m_data = m_own ? dbg_wdata : cpu_wdata;
        m_act  = 1;
        m_g    = cyc;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic xfer(input bit is_dbg, input bit wr, input logic [5:0] a,
                      input logic [31:0] d, output int lat, output int strs);
    bit got;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    end
    lat = 0; strs = 0; got = 0;
    #1;
    if (!is_dbg) chk("stall_on_req", 32'(cpu_stall), 32'd1);
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      if (dm_str) strs++;
      got = is_dbg ? dbg_ack : cpu_ack;
      if (!got && !is_dbg) chk("stall_hold", 32'(cpu_stall), 32'd1);
    end
    chk(is_dbg ? "dbg_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
  endtask

  task automatic contend(input int exp_ca, input int exp_da);
    int ca, da;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 6'd5;
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 6'd63;
    ca = 0; da = 0;
    for (int i = 1; i <= 12 && (ca == 0 || da == 0); i++) begin
      tick();
      if (cpu_ack && ca == 0) begin ca = i; cpu_req = 1'b0; end
      if (dbg_ack && da == 0) begin da = i; dbg_req = 1'b0; end
    end
    chk("cont_cpu_cycle", 32'(ca), 32'(exp_ca));
    chk("cont_dbg_cycle", 32'(da), 32'(exp_da));
    chk("cont_cpu_rdata", cpu_rdata, 32'h1234ABCD);
    chk("cont_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    int lat, strs;
    checks = 0; errors = 0;
    clr = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 6'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 6'd0; dbg_wdata = 32'd0;
    repeat (3) tick();
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_dm_sel", 32'(dm_sel), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dm_ra", 32'(dm_ra), 32'd0);
    clr = 1'b1;
    tick();

    // CPU read of word 5, debug idle.
    xfer(0, 0, 6'd5, 32'd0, lat, strs);
    chk("rd5_latency", 32'(lat), 32'd2);
    chk("rd5_rdata", cpu_rdata, 32'h1234ABCD);
    chk("rd5_no_store", 32'(strs), 32'd0);

    // Debug write of word 63, then CPU reads it back.
    xfer(1, 1, 6'd63, 32'hDEADBEEF, lat, strs);
    chk("wr63_latency", 32'(lat), 32'd2);
    chk("wr63_str_pulses", 32'(strs), 32'd1);
    xfer(0, 0, 6'd63, 32'd0, lat, strs);
    chk("rd63_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd63_dbg_rdata_untouched", dbg_rdata, 32'd0);

    // Write completions leave rdata; CPU reads leave dbg_rdata.
    xfer(1, 1, 6'd10, 32'h00000055, lat, strs);
    xfer(0, 0, 6'd10, 32'd0, lat, strs);
    chk("rd10_rdata", cpu_rdata, 32'h00000055);
    xfer(0, 1, 6'd11, 32'h00000077, lat, strs);
    chk("wr11_rdata_kept", cpu_rdata, 32'h00000055);
    chk("wr11_str_pulses", 32'(strs), 32'd1);
    xfer(1, 0, 6'd5, 32'd0, lat, strs);
    chk("dbg_rd5_rdata", dbg_rdata, 32'h1234ABCD);
    xfer(0, 0, 6'd63, 32'd0, lat, strs);
    chk("dbg_rdata_after_cpu_rd", dbg_rdata, 32'h1234ABCD);
    chk("cpu_rd63_again", cpu_rdata, 32'hDEADBEEF);

    // Contention; last grant so far went to the CPU.
`ifdef DM_ARB_RR_EN
    contend(5, 2);
`else
    contend(2, 5);
`endif

    // CPU request raised and dropped while debug is being served: ignored.
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 6'd5;
    tick();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 6'd20; cpu_wdata = 32'hBAD0BAD0;
    tick();
    chk("drop_dbg_ack", 32'(dbg_ack), 32'd1);
    dbg_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_no_ack", 32'(cpu_ack), 32'd0);
    end
    chk("drop_mem20", mem[20], 32'hA5000014);

    // Request dropped after it was latched still completes.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 6'd11;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("late_drop_ack", 32'(cpu_ack), 32'd1);
    chk("late_drop_rdata", cpu_rdata, 32'h00000077);
    tick();

    // Reset during ACCESS of a CPU write aborts it.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 6'd30; cpu_wdata = 32'hCAFEF00D;
    tick();
    chk("abort_str_before", 32'(dm_str), 32'd1);
    chk("abort_ra_before", 32'(dm_ra), 32'd30);
    clr = 1'b0; cpu_req = 1'b0;
    #1;
    chk("abort_str_gated", 32'(dm_str), 32'd0);
    tick();
    chk("abort_sel_after", 32'(dm_sel), 32'd0);
    chk("abort_str_after", 32'(dm_str), 32'd0);
    chk("abort_rdata_clr", cpu_rdata, 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    end
    chk("abort_mem30", mem[30], 32'hA500001E);

    // After reset the first contended grant goes to the CPU in both modes.
    contend(2, 5);

    for (int i = 0; i < 64; i++) chk("mem_vs_ref", mem[i], ref_mem[i]);
    chk("mem11_literal", mem[11], 32'h00000077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
